// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keypad_pkg
// Purpose : Shared types and constants for the 4x4 hex keypad scanner.
//           Holds the scanner state encoding, the keyCode valid flag, the
//           row/column to hex-value keymap and small lookup helpers.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package keypad_pkg;

  // Scanner states
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  // Bit 4 of keyCode marks a valid key
  localparam logic KEY_VALID = 1'b1;

  // Keymap, nibble (row*4 + col) holds the key value, row 0 in the low 16 bits.
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  // Hex value of the key at (row_idx, col_idx)
  function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
    logic [5:0] bit_base;
    bit_base = {row_idx, col_idx, 2'b00};
    return KEYMAP[bit_base +: 4];
  endfunction

  // Active-low one-cold row drive pattern for a row index
  function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
    return ~(4'b0001 << row_idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
// Module  : keypad_sync
// Purpose : Two-flop synchroniser for asynchronous, active-low inputs.
//           Both stages reset to all-ones (the idle level of pulled-up lines).
// Ports   : clock  - system clock
//           reset  - asynchronous active-low reset
//           d      - asynchronous input bus
//           q      - synchronised output bus
// Rev     : 1.0  initial release
// ============================================================================
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scanner
// Purpose : Scans a 4x4 active-low matrix keypad, synchronises and debounces
//           the column returns and reports each press once as a one-cycle
//           newKey strobe with keyCode = {1'b1, value}.
// Ports   : clock    - system clock, all logic on the rising edge
//           reset    - asynchronous active-low reset (synchronous release)
//           cols     - column returns, active-low, asynchronous
//           rows     - row drive, active-low, exactly one bit low
//           newKey   - one-cycle strobe, debounced press on keyCode
//           keyCode  - {valid, value[3:0]}, holds between strobes
// Rev     : 1.0  initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,  // cycles per row before sampling, >= 4
  parameter int DEBOUNCE = 8      // identical samples to accept, 2..255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       newKey,
  output logic [4:0] keyCode
);

  localparam int              DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]       DB_TARGET  = 8'(DEBOUNCE);

  // --------------------------------------------------------------------------
  // Reset conditioning: assertion reaches every flop immediately, release is
  // aligned to the clock so no flop sees a release near an edge.
  // --------------------------------------------------------------------------
  logic [1:0] rst_pipe;
  logic       rst_int;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int = rst_pipe[1];

  // --------------------------------------------------------------------------
  // Column synchroniser
  // --------------------------------------------------------------------------
  logic [3:0] cs;

  keypad_sync #(
    .WIDTH (4)
  ) u_sync (
    .clock (clock),
    .reset (rst_int),
    .d     (cols),
    .q     (cs)
  );

  // --------------------------------------------------------------------------
  // Dwell counter: free-running 0..SCAN_DIV-1, one sample per wrap.
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] dwell;
  logic             sample;

  assign sample = (dwell == DWELL_LAST);

  always_ff @(posedge clock or negedge rst_int) begin
    if (!rst_int) begin
      dwell <= '0;
    end else if (sample) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Column decode: a press is only considered when exactly one column is low;
  // zero or several low columns (ghosting / multi-key) are not a press.
  // --------------------------------------------------------------------------
  logic       one_low;
  logic [1:0] col_idx;

  always_comb begin
    one_low = 1'b1;
    col_idx = 2'd0;
    case (cs)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Scanner FSM with registered outputs.
  // newKey and keyCode are loaded on the edge that enters ST_EMIT, so they are
  // valid for exactly the cycle the FSM spends in ST_EMIT.
  // --------------------------------------------------------------------------
  state_t     state;
  logic [1:0] row_idx;
  logic [1:0] key_row;
  logic [1:0] key_col;
  logic [3:0] key_pat;
  logic [7:0] count;

  always_ff @(posedge clock or negedge rst_int) begin
    if (!rst_int) begin
      state   <= ST_SCAN;
      row_idx <= 2'd0;
      key_row <= 2'd0;
      key_col <= 2'd0;
      key_pat <= 4'b1111;
      count   <= 8'd0;
      rows    <= 4'b1110;
      newKey  <= 1'b0;
      keyCode <= 5'b00000;
    end else begin
      newKey <= 1'b0;

      case (state)
        ST_SCAN: begin
          if (sample) begin
            if (one_low) begin
              // Park on this row; the capturing sample is the first match.
              state   <= ST_DEBOUNCE;
              key_row <= row_idx;
              key_col <= col_idx;
              key_pat <= cs;
              count   <= 8'd1;
            end else begin
              row_idx <= row_idx + 2'd1;
              rows    <= row_drive(row_idx + 2'd1);
            end
          end
        end

        ST_DEBOUNCE: begin
          if (sample) begin
            if (cs == key_pat) begin
              if (count + 8'd1 == DB_TARGET) begin
                state   <= ST_EMIT;
                newKey  <= 1'b1;
                keyCode <= {KEY_VALID, key_lookup(key_row, key_col)};
                count   <= 8'd0;
              end else begin
                count <= count + 8'd1;
              end
            end else begin
              // Bounce or different key: resume scanning past this row.
              state   <= ST_SCAN;
              row_idx <= key_row + 2'd1;
              rows    <= row_drive(key_row + 2'd1);
              count   <= 8'd0;
            end
          end
        end

        ST_EMIT: begin
          state <= ST_HOLD;
          count <= 8'd0;
        end

        ST_HOLD: begin
          // Only a run of fully released samples ends the press; anything
          // else, including a second key on the parked row, restarts the run.
          if (sample) begin
            if (cs == 4'b1111) begin
              if (count + 8'd1 == DB_TARGET) begin
                state   <= ST_SCAN;
                row_idx <= 2'd0;
                rows    <= 4'b1110;
                count   <= 8'd0;
              end else begin
                count <= count + 8'd1;
              end
            end else begin
              count <= 8'd0;
            end
          end
        end

        default: begin
          state   <= ST_SCAN;
          row_idx <= 2'd0;
          rows    <= 4'b1110;
          count   <= 8'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_scanner
// Purpose : Self-checking bench for keypad_scanner with a keypad model that
//           pulls a column low only while the pressed key's row is driven.
// Rev     : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int S       = 4;
  localparam int D       = 3;
  localparam int LAT_MAX = (4 + D) * S + 3;
  localparam int GAP_MIN = 2 * D * S;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       newKey;
  logic [4:0] keyCode;

  logic [15:0] pressed = 16'h0000;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         strobes  = 0;
  int         last_strobe_cyc = -1;
  logic [4:0] last_obs   = 5'd0;
  logic [4:0] code_track = 5'd0;
  logic       prev_nk    = 1'b0;
  string      keymap_str = "123A456B789CE0FD";

  typedef struct {
    int         idx;
    int         hold;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs [16];

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV (S),
    .DEBOUNCE (D)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .cols    (cols),
    .rows    (rows),
    .newKey  (newKey),
    .keyCode (keyCode)
  );

  // Keypad: column c is low when a pressed key in column c sits on a driven row
  always_comb begin
    cols = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4 + c] && !rows[r]) cols[c] = 1'b0;
  end

  // Expected keyCode from the printed keypad legend
  function automatic logic [4:0] model_code(input int idx);
    int ch;
    int v;
    ch = int'(keymap_str[idx]);
    if (ch >= 48 && ch <= 57) v = ch - 48;
    else                      v = ch - 55;
    return {1'b1, v[3:0]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle invariants and strobe logging, sampled 1 time unit after the edge
  task automatic observe();
    if (reset) begin
      chk("rows_one_low", $countones(~rows), 1);
      if (newKey) begin
        chk("strobe_single_cycle", int'(prev_nk), 0);
        if (last_strobe_cyc >= 0)
          chk("strobe_gap", int'(cyc - last_strobe_cyc >= GAP_MIN), 1);
        strobes++;
        last_obs        = keyCode;
        last_strobe_cyc = cyc;
        code_track      = keyCode;
      end else begin
        chk("keycode_hold", int'(keyCode), int'(code_track));
      end
      prev_nk = newKey;
    end else begin
      code_track      = 5'd0;
      prev_nk         = 1'b0;
      last_strobe_cyc = -1;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      observe();
    end
  endtask

  initial begin
    int         s0;
    int         t_press;
    int         bad;
    int         found;
    int         idx;
    int         glitch;
    logic [3:0] seen;

    vecs[0]  = '{0,  45, 5'b10001};
    vecs[1]  = '{1,  50, 5'b10010};
    vecs[2]  = '{2,  45, 5'b10011};
    vecs[3]  = '{3,  55, 5'b11010};
    vecs[4]  = '{4,  45, 5'b10100};
    vecs[5]  = '{5,  60, 5'b10101};
    vecs[6]  = '{6,  45, 5'b10110};
    vecs[7]  = '{7,  50, 5'b11011};
    vecs[8]  = '{8,  45, 5'b10111};
    vecs[9]  = '{9,  45, 5'b11000};
    vecs[10] = '{10, 65, 5'b11001};
    vecs[11] = '{11, 45, 5'b11100};
    vecs[12] = '{12, 45, 5'b11110};
    vecs[13] = '{13, 40, 5'b10000};
    vecs[14] = '{14, 45, 5'b11111};
    vecs[15] = '{15, 45, 5'b11101};

    // ---------------- reset values ----------------
    tick(3);
    chk("reset_rows",    int'(rows),    int'(4'b1110));
    chk("reset_newKey",  int'(newKey),  0);
    chk("reset_keyCode", int'(keyCode), 0);
    reset = 1'b1;
    tick(10);

    // ---------------- table: every key once ----------------
    for (int i = 0; i < 16; i++) begin
      s0      = strobes;
      t_press = cyc;
      pressed = 16'(1) << vecs[i].idx;
      tick(vecs[i].hold);
      chk($sformatf("tbl%0d_count", i), strobes - s0, 1);
      chk($sformatf("tbl%0d_code", i), int'(last_obs), int'(vecs[i].exp));
      chk($sformatf("tbl%0d_latency", i), int'(last_strobe_cyc - t_press <= LAT_MAX), 1);
      pressed = 16'h0000;
      tick(40);
      chk($sformatf("tbl%0d_no_release_strobe", i), strobes - s0, 1);
    end

    // ---------------- "1" held 200 cycles, parked, then released ----------------
    s0      = strobes;
    pressed = 16'h0001;
    tick(40);
    bad = 0;
    for (int k = 0; k < 160; k++) begin
      tick(1);
      if (rows != 4'b1110) bad++;
    end
    chk("hold1_parked", bad, 0);
    chk("hold1_count", strobes - s0, 1);
    chk("hold1_code", int'(last_obs), int'(5'b10001));
    pressed = 16'h0000;
    bad = 0;
    for (int k = 0; k < 14; k++) begin
      tick(1);
      if (rows != 4'b1110) bad++;
    end
    chk("hold1_release_debounced", bad, 0);
    seen = 4'b0000;
    for (int k = 0; k < 24; k++) begin
      tick(1);
      seen = seen | ~rows;
    end
    chk("hold1_scan_resumed", int'(seen), int'(4'b1111));
    chk("hold1_no_release_strobe", strobes - s0, 1);

    // ---------------- "3" then "D" ----------------
    s0      = strobes;
    pressed = 16'h0004;
    tick(60);
    chk("key3_code", int'(last_obs), int'(5'b10011));
    pressed = 16'h0000;
    tick(40);
    pressed = 16'h8000;
    tick(60);
    chk("keyD_code", int'(last_obs), int'(5'b11101));
    pressed = 16'h0000;
    tick(40);
    chk("key3D_count", strobes - s0, 2);

    // ---------------- "5" bouncing, then steady ----------------
    s0 = strobes;
    for (int k = 0; k < 10; k++) begin
      pressed = (k % 2 == 0) ? 16'h0020 : 16'h0000;
      tick(6);
    end
    chk("bounce5_no_strobe", strobes - s0, 0);
    pressed = 16'h0020;
    tick(60);
    chk("bounce5_count", strobes - s0, 1);
    chk("bounce5_code", int'(last_obs), int'(5'b10101));
    pressed = 16'h0000;
    tick(40);

    // ---------------- "1"+"2" together, then release "2" ----------------
    s0      = strobes;
    pressed = 16'h0003;
    seen    = 4'b0000;
    for (int k = 0; k < 60; k++) begin
      tick(1);
      seen = seen | ~rows;
    end
    chk("dual_no_strobe", strobes - s0, 0);
    chk("dual_rotating", int'(seen), int'(4'b1111));
    pressed = 16'h0001;
    tick(40);
    chk("dual_release2_count", strobes - s0, 1);
    chk("dual_release2_code", int'(last_obs), int'(5'b10001));
    pressed = 16'h0000;
    tick(40);

    // ---------------- "0" held 500 cycles ----------------
    s0      = strobes;
    pressed = 16'h2000;
    tick(500);
    chk("hold0_count", strobes - s0, 1);
    chk("hold0_code", int'(last_obs), int'(5'b10000));
    pressed = 16'h0000;
    tick(60);
    chk("hold0_no_release_strobe", strobes - s0, 1);
    chk("hold0_keycode_kept", int'(keyCode), int'(5'b10000));

    // ---------------- reset during DEBOUNCE of "9" ----------------
    s0      = strobes;
    pressed = 16'h0400;
    found   = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      tick(1);
      if (rows == 4'b1011) found = 1;
    end
    chk("key9_row2_reached", found, 1);
    tick(6);
    chk("key9_parked", int'(rows), int'(4'b1011));
    chk("key9_no_strobe_yet", strobes - s0, 0);
    reset = 1'b0;
    #1;
    chk("rst_mid_rows",    int'(rows),    int'(4'b1110));
    chk("rst_mid_newKey",  int'(newKey),  0);
    chk("rst_mid_keyCode", int'(keyCode), 0);
    tick(3);
    reset = 1'b1;
    s0    = strobes;
    tick(12);
    chk("rst_no_strobe_after_release", strobes - s0, 0);
    tick(40);
    chk("rst_fresh_scan_count", strobes - s0, 1);
    chk("rst_fresh_scan_code", int'(last_obs), int'(5'b11001));
    pressed = 16'h0000;
    tick(40);

    // ---------------- randomized presses vs keymap model ----------------
    for (int i = 0; i < 12; i++) begin
      idx    = int'($urandom_range(15, 0));
      glitch = int'($urandom_range(5, 0));
      s0     = strobes;
      if (glitch > 0) begin
        pressed = 16'(1) << idx;
        tick(glitch);
        pressed = 16'h0000;
        tick(5);
      end
      t_press = cyc;
      pressed = 16'(1) << idx;
      tick(int'($urandom_range(90, 35)));
      chk($sformatf("rnd%0d_count_key%0d", i, idx), strobes - s0, 1);
      chk($sformatf("rnd%0d_code_key%0d", i, idx), int'(last_obs), int'(model_code(idx)));
      chk($sformatf("rnd%0d_latency", i), int'(last_strobe_cyc - t_press <= LAT_MAX), 1);
      pressed = 16'h0000;
      tick(int'($urandom_range(70, 30)));
      chk($sformatf("rnd%0d_no_release_strobe", i), strobes - s0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
